// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register: multi-cycle data memory access,
// upstream stall, branch/jump resolution and write-back field registration.
module mem_wb_stage #(
    parameter int ADDR_BITS = 8,
    parameter int MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_reg_zero,
    input  logic        EX_MEM_reg_Branch,
    input  logic        EX_MEM_reg_jump,
    input  logic        EX_MEM_reg_MemRead,
    input  logic        EX_MEM_reg_MemWrite,
    input  logic        EX_MEM_reg_MemtoReg,
    input  logic        EX_MEM_reg_RegWrite,
    input  logic [31:0] EX_MEM_reg_ALU_out,
    input  logic [31:0] EX_MEM_reg_WD,
    input  logic [4:0]  EX_MEM_reg_WN,
    input  logic [31:0] EX_MEM_reg_b_tgt,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] pc_tgt,
    output logic        align_err,
    output logic        MEM_WB_reg_RegWrite,
    output logic        MEM_WB_reg_MemtoReg,
    output logic [31:0] MEM_WB_reg_RD,
    output logic [31:0] MEM_WB_reg_ALU_out,
    output logic [4:0]  MEM_WB_reg_WN
);

    localparam int CW = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic            stall, commit;
    logic [31:0]     mem [0:2**ADDR_BITS-1];

    logic                 is_mem, aligned, acc, misalign, is_load;
    logic [ADDR_BITS-1:0] idx;
    logic                 unused_addr_bits;

    assign is_mem   = EX_MEM_reg_MemRead | EX_MEM_reg_MemWrite;
    assign aligned  = (EX_MEM_reg_ALU_out[1:0] == 2'b00);
    assign acc      = is_mem & aligned;
    assign misalign = is_mem & ~aligned;
    assign is_load  = EX_MEM_reg_MemRead & ~EX_MEM_reg_MemWrite;
    // Upper address bits are dropped so the word index wraps around the array.
    assign idx      = EX_MEM_reg_ALU_out[ADDR_BITS+1:2];
    assign unused_addr_bits = ^EX_MEM_reg_ALU_out[31:ADDR_BITS+2];

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (acc && (MEM_LAT > 1)) begin
                    stall      = 1'b1;
                    next_state = WAIT;
                    next_cnt   = CW'(1);
                end else begin
                    commit = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == LAST) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    stall    = 1'b1;
                    next_cnt = cnt + CW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign mem_stall = stall & ~rst;
    assign align_err = misalign & ~rst;
    assign pc_src    = ~stall & ~rst &
                       ((EX_MEM_reg_Branch & EX_MEM_reg_zero) | EX_MEM_reg_jump);
    assign pc_tgt    = EX_MEM_reg_b_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            MEM_WB_reg_RegWrite <= 1'b0;
            MEM_WB_reg_MemtoReg <= 1'b0;
            MEM_WB_reg_RD       <= '0;
            MEM_WB_reg_ALU_out  <= '0;
            MEM_WB_reg_WN       <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (commit) begin
                MEM_WB_reg_RegWrite <= EX_MEM_reg_RegWrite & ~misalign;
                MEM_WB_reg_MemtoReg <= EX_MEM_reg_MemtoReg;
                MEM_WB_reg_RD       <= (is_load && aligned) ? mem[idx] : 32'd0;
                MEM_WB_reg_ALU_out  <= EX_MEM_reg_ALU_out;
                MEM_WB_reg_WN       <= EX_MEM_reg_WN;
            end else begin
                MEM_WB_reg_RegWrite <= 1'b0;
            end
        end
    end

    // The array has no reset; a store lands only on its commit edge.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc && EX_MEM_reg_MemWrite)
            mem[idx] <= EX_MEM_reg_WD;
    end

endmodule
